// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: register scoreboard with RAW/WAW stall,
// single-entry valid/ready output register, writeback clear and flush.
module decode_issue_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned OP_W     = 6,
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REG_W-1:0] in_readA,
    input  logic [REG_W-1:0] in_readB,
    input  logic             in_immSel,
    input  logic             in_wen,
    input  logic [REG_W-1:0] in_rd,
    input  logic [OP_W-1:0]  in_aluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_rd,
    output logic             out_wen,
    output logic [OP_W-1:0]  out_aluOp,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wb_err
);

    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  wb_mask;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  beff;
    logic              wb_dec;
    logic              pend_next_full;
    logic              rd_nz;
    logic              hazard;
    logic              accept;
    logic              set_en;

    // Hazard detection against the scoreboard with same-cycle writeback bypass
    always_comb begin
        wb_mask        = wb_valid ? (NREGS'(1) << wb_rd) : '0;
        beff           = busy_vec & ~wb_mask;
        wb_dec         = wb_valid & busy_vec[wb_rd];
        pend_next_full = (pend_q - PEND_W'(wb_dec)) == PEND_W'(PEND_MAX);
        rd_nz          = in_rd != '0;
        hazard         = in_valid & (beff[in_readA]
                                   | (~in_immSel & beff[in_readB])
                                   | (in_wen & rd_nz & (beff[in_rd] | pend_next_full)));
        in_ready       = ~flush & ~hazard & ((state_q == EMPTY) | out_ready);
        accept         = in_valid & in_ready;
        set_en         = accept & in_wen & rd_nz;
        set_mask       = set_en ? (NREGS'(1) << in_rd) : '0;
    end

    // Scoreboard and pending-count next state; a same-register set beats the clear
    always_comb begin
        busy_d = (busy_vec & ~(wb_dec ? wb_mask : '0)) | set_mask;
        pend_d = pend_q + PEND_W'(set_en) - PEND_W'(wb_dec);
        if (flush) begin
            busy_d = '0;
            pend_d = '0;
        end
    end

    // Output-register FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    assign out_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec  <= '0;
            pend_q    <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_aluOp <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            busy_vec <= busy_d;
            pend_q   <= pend_d;
            if (accept) begin
                out_rd    <= in_rd;
                out_wen   <= in_wen & rd_nz;
                out_aluOp <= in_aluOp;
            end
            if (hazard && !flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (wb_valid && !busy_vec[wb_rd]) wb_err <= 1'b1;
        end
    end

endmodule
